// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
//   Packet controller on the read side of the UART RX FIFO (sclk domain).
//   Pops bytes from the FIFO, frames them into packets of a programmed size,
//   and presents them downstream on a valid/ready stream with a last marker.
//   An inter-byte idle timeout aborts a stalled packet, and sticky error
//   status (timeout, overflow, parity) is collected for the host.
//
// Ports
//   sclk, rstn        clock, synchronous active-low reset
//   enable_i          controller enable; low aborts any packet in progress
//   data_size_r       bytes per packet (0 treated as 1), latched per packet
//   timeout_r         max idle cycles between bytes in a packet (0 = off)
//   fifo_empty_i      RX FIFO empty
//   fifo_rd_o         RX FIFO read strobe (data valid the following cycle)
//   fifo_data_i       RX FIFO read data
//   parity_err_i      parity error from the receiver
//   fifo_full_err_i   write-while-full pulse from the receiver
//   pkt_data_o/pkt_valid_o/pkt_ready_i/pkt_last_o  downstream stream
//   pkt_done_o        one-cycle pulse after the final byte is accepted
//   timeout_o         one-cycle pulse when a packet is aborted by timeout
//   err_status_o      sticky {timeout, overflow, parity}
//   err_clr_i         clears err_status_o (a same-cycle set wins)
//   irq_o             OR of err_status_o bits plus pkt_done_o
//   byte_cnt_o        bytes accepted in the current packet
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 sclk,
  input  logic                 rstn,
  input  logic                 enable_i,
  input  logic [15:0]          data_size_r,
  input  logic [TIMEOUT_W-1:0] timeout_r,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_o,
  input  logic [7:0]           fifo_data_i,
  input  logic                 parity_err_i,
  input  logic                 fifo_full_err_i,
  output logic [7:0]           pkt_data_o,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic                 pkt_last_o,
  output logic                 pkt_done_o,
  output logic                 timeout_o,
  output logic [2:0]           err_status_o,
  input  logic                 err_clr_i,
  output logic                 irq_o,
  output logic [15:0]          byte_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          size_q, size_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic                 tmo_q, tmo_d;
  logic [2:0]           err_q, err_d;
  logic                 expire;

  // A programmed size of zero still yields one-byte packets.
  function automatic logic [15:0] eff_size(input logic [15:0] s);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

  // State register
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      size_q     <= 16'd1;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = '0;
    data_d     = data_q;
    last_d     = last_q;
    tmo_d      = 1'b0;
    expire     = 1'b0;

    if (!enable_i) begin
      // Abort: anything popped in RD/LAT is simply never captured/presented.
      state_d    = S_IDLE;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty_i) begin
            size_d  = eff_size(data_size_r);
            state_d = S_RD;
          end
        end
        S_GAP: begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
          // A byte arriving in the expiry cycle takes priority over timeout.
          if (!fifo_empty_i) begin
            tmo_cnt_d = '0;
            state_d   = S_RD;
          end else if ((timeout_r != '0) &&
                       (tmo_cnt_q == timeout_r - TIMEOUT_W'(1))) begin
            expire     = 1'b1;
            tmo_d      = 1'b1;
            tmo_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = S_IDLE;
          end
        end
        S_RD: begin
          state_d = S_LAT;
        end
        S_LAT: begin
          data_d  = fifo_data_i;
          // 17-bit compare so a full 65535-byte packet cannot alias.
          last_d  = (({1'b0, byte_cnt_q} + 17'd1) == {1'b0, size_q});
          state_d = S_OUT;
        end
        S_OUT: begin
          // Back-pressure stalls here; the idle counter stays cleared.
          if (pkt_ready_i) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            state_d    = last_q ? S_DONE : S_GAP;
          end
        end
        S_DONE: begin
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Sticky errors: clear first, then same-cycle sets override the clear.
    err_d = err_clr_i ? 3'b000 : err_q;
    err_d = err_d | {expire, fifo_full_err_i, parity_err_i};
  end

  // Strobes are decoded from the registered state; qualifying with enable_i
  // keeps the FIFO untouched and the stream quiet once the block is disabled.
  assign fifo_rd_o    = (state_q == S_RD)   && enable_i;
  assign pkt_valid_o  = (state_q == S_OUT)  && enable_i;
  assign pkt_done_o   = (state_q == S_DONE) && enable_i;
  assign pkt_data_o   = data_q;
  assign pkt_last_o   = last_q && pkt_valid_o;
  assign timeout_o    = tmo_q;
  assign err_status_o = err_q;
  assign irq_o        = (|err_q) || pkt_done_o;
  assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
//   Self-checking bench for uart_rx_pkt_ctrl. A small FIFO model feeds the
//   DUT; expected stream bytes (data, last, byte index) are queued when the
//   stimulus is written and compared when the DUT hands them off.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

  logic        sclk = 1'b0;
  logic        rstn;
  logic        enable_i;
  logic [15:0] data_size_r;
  logic [15:0] timeout_r;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic [7:0]  fifo_data_i;
  logic        parity_err_i;
  logic        fifo_full_err_i;
  logic [7:0]  pkt_data_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i;
  logic        pkt_last_o;
  logic        pkt_done_o;
  logic        timeout_o;
  logic [2:0]  err_status_o;
  logic        err_clr_i;
  logic        irq_o;
  logic [15:0] byte_cnt_o;

  always #10 sclk = ~sclk;

  uart_rx_pkt_ctrl #(.TIMEOUT_W(16)) dut (
    .sclk            (sclk),
    .rstn            (rstn),
    .enable_i        (enable_i),
    .data_size_r     (data_size_r),
    .timeout_r       (timeout_r),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_o       (fifo_rd_o),
    .fifo_data_i     (fifo_data_i),
    .parity_err_i    (parity_err_i),
    .fifo_full_err_i (fifo_full_err_i),
    .pkt_data_o      (pkt_data_o),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_ready_i     (pkt_ready_i),
    .pkt_last_o      (pkt_last_o),
    .pkt_done_o      (pkt_done_o),
    .timeout_o       (timeout_o),
    .err_status_o    (err_status_o),
    .err_clr_i       (err_clr_i),
    .irq_o           (irq_o),
    .byte_cnt_o      (byte_cnt_o)
  );

  // FIFO model: bench writes, DUT read strobe returns data next cycle.
  logic [7:0] fifo_mem [0:255];
  int         push_cnt = 0;
  int         pop_cnt  = 0;

  assign fifo_empty_i = (push_cnt == pop_cnt);

  always @(posedge sclk) begin
    if (fifo_rd_o) begin
      fifo_data_i <= fifo_mem[pop_cnt[7:0]];
      pop_cnt     <= pop_cnt + 1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [15:0] idx;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples well after the drivers settle and before the next edge.
  int cyc = 0, rd_cnt = 0, done_cnt = 0, tmo_cnt = 0, hs_cyc = 0, tmo_cyc = 0;

  always @(negedge sclk) begin
    exp_t e;
    #4;
    cyc++;
    if (pkt_valid_o && pkt_ready_i) begin
      chk("sb_has_entry", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("data", pkt_data_o, e.d);
        chk("last", pkt_last_o, e.l);
        chk("bcnt", byte_cnt_o, e.idx);
      end
      hs_cyc = cyc;
    end
    if (pkt_done_o) begin
      done_cnt++;
      chk("done_irq", irq_o, 1);
    end
    if (timeout_o) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    if (fifo_rd_o) begin
      rd_cnt++;
      chk("rd_en", enable_i, 1);
      chk("rd_nonempty", fifo_empty_i, 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge sclk);
      #1;
    end
  endtask

  task automatic fpush(input logic [7:0] d);
    fifo_mem[push_cnt[7:0]] = d;
    push_cnt++;
  endtask

  task automatic epush(input logic [7:0] d, input logic [15:0] idx, input logic l);
    exp_t e;
    e.d = d; e.idx = idx; e.l = l;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, (done_cnt >= target), 1);
  endtask

  initial begin
    int r0, d0, t0, k, b;
    logic ok;

    rstn = 1'b0; enable_i = 1'b0; data_size_r = 16'd0; timeout_r = 16'd0;
    pkt_ready_i = 1'b0; parity_err_i = 1'b0; fifo_full_err_i = 1'b0;
    err_clr_i = 1'b0;
    tick(3);
    chk("rst_rd",    fifo_rd_o,    0);
    chk("rst_valid", pkt_valid_o,  0);
    chk("rst_last",  pkt_last_o,   0);
    chk("rst_done",  pkt_done_o,   0);
    chk("rst_tmo",   timeout_o,    0);
    chk("rst_err",   err_status_o, 0);
    chk("rst_irq",   irq_o,        0);
    chk("rst_bcnt",  byte_cnt_o,   0);
    chk("rst_data",  pkt_data_o,   0);
    rstn = 1'b1;
    tick();

    // Three-byte packet, no timeout, free-flowing downstream.
    data_size_r = 16'd3; timeout_r = 16'd0; pkt_ready_i = 1'b1;
    r0 = rd_cnt; d0 = done_cnt;
    epush(8'h11, 16'd0, 1'b0); fpush(8'h11);
    epush(8'h22, 16'd1, 1'b0); fpush(8'h22);
    epush(8'h33, 16'd2, 1'b1); fpush(8'h33);
    enable_i = 1'b1;
    wait_done(d0 + 1, 200, "t1_done_seen");
    tick(2);
    chk("t1_rd_pulses", rd_cnt - r0, 3);
    chk("t1_done_cnt",  done_cnt - d0, 1);
    chk("t1_bcnt_zero", byte_cnt_o, 0);
    chk("t1_sb_empty",  sbq.size(), 0);

    // Lone byte in a two-byte packet: idle timeout after 10 gap cycles.
    data_size_r = 16'd2; timeout_r = 16'd10;
    t0 = tmo_cnt; d0 = done_cnt;
    epush(8'h5A, 16'd0, 1'b0); fpush(8'h5A);
    k = 0;
    while (tmo_cnt == t0 && k < 100) begin tick(); k++; end
    chk("t2_tmo_seen", (tmo_cnt == t0 + 1), 1);
    tick();
    chk("t2_gap_len", tmo_cyc - hs_cyc, 11);
    chk("t2_err",     err_status_o, 3'b100);
    chk("t2_irq",     irq_o, 1);
    chk("t2_bcnt",    byte_cnt_o, 0);
    chk("t2_no_done", done_cnt - d0, 0);
    epush(8'h6B, 16'd0, 1'b0); fpush(8'h6B);
    epush(8'h7C, 16'd1, 1'b1); fpush(8'h7C);
    wait_done(d0 + 1, 200, "t2_new_pkt_done");
    chk("t2_one_tmo", tmo_cnt - t0, 1);
    err_clr_i = 1'b1; tick();
    err_clr_i = 1'b0; tick();
    chk("t2_err_clr", err_status_o, 0);

    // Back-pressure: byte held stable in OUT, no re-read, no timeout.
    data_size_r = 16'd1; timeout_r = 16'd3; pkt_ready_i = 1'b0;
    r0 = rd_cnt; t0 = tmo_cnt; d0 = done_cnt;
    epush(8'hA5, 16'd0, 1'b1); fpush(8'hA5);
    k = 0;
    while (!pkt_valid_o && k < 50) begin tick(); k++; end
    chk("t3_valid_seen", pkt_valid_o, 1);
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (!pkt_valid_o || pkt_data_o !== 8'hA5 || !pkt_last_o) ok = 1'b0;
    end
    chk("t3_hold",    ok, 1);
    chk("t3_one_rd",  rd_cnt - r0, 1);
    chk("t3_no_tmo",  tmo_cnt - t0, 0);
    chk("t3_no_done", done_cnt - d0, 0);
    pkt_ready_i = 1'b1;
    wait_done(d0 + 1, 50, "t3_done_seen");

    // Disable during LAT of byte 2 of 4; that byte is dropped.
    data_size_r = 16'd4; timeout_r = 16'd0;
    d0 = done_cnt;
    epush(8'h01, 16'd0, 1'b0); fpush(8'h01);
    fpush(8'h02); fpush(8'h03); fpush(8'h04);
    k = 0; b = 0;
    while (k < 2 && b < 100) begin
      tick();
      if (fifo_rd_o) k++;
      b++;
    end
    chk("t4_reach_rd2", k, 2);
    tick();
    enable_i = 1'b0;
    tick();
    chk("t4_valid_off", pkt_valid_o, 0);
    chk("t4_bcnt_zero", byte_cnt_o, 0);
    r0 = rd_cnt;
    tick(4);
    chk("t4_no_rd_off", rd_cnt - r0, 0);
    chk("t4_no_done",   done_cnt - d0, 0);
    epush(8'h03, 16'd0, 1'b0);
    epush(8'h04, 16'd1, 1'b0);
    epush(8'h05, 16'd2, 1'b0); fpush(8'h05);
    epush(8'h06, 16'd3, 1'b1); fpush(8'h06);
    enable_i = 1'b1;
    wait_done(d0 + 1, 200, "t4_fresh_done");
    chk("t4_sb_empty", sbq.size(), 0);

    // Sticky errors: set wins over a same-cycle clear.
    fifo_full_err_i = 1'b1; tick();
    fifo_full_err_i = 1'b0; tick();
    chk("t5_ovf", err_status_o, 3'b010);
    chk("t5_irq_ovf", irq_o, 1);
    parity_err_i = 1'b1; err_clr_i = 1'b1; tick();
    parity_err_i = 1'b0; err_clr_i = 1'b0; tick();
    chk("t5_par_wins", err_status_o, 3'b001);
    err_clr_i = 1'b1; tick();
    err_clr_i = 1'b0; tick();
    chk("t5_clr", err_status_o, 3'b000);
    chk("t5_irq_off", irq_o, 0);

    // Size zero behaves as one-byte packets.
    data_size_r = 16'd0;
    d0 = done_cnt;
    epush(8'hC1, 16'd0, 1'b1); fpush(8'hC1);
    epush(8'hC2, 16'd0, 1'b1); fpush(8'hC2);
    wait_done(d0 + 2, 200, "t6_done_seen");
    tick(2);
    chk("t6_done_cnt", done_cnt - d0, 2);
    chk("t6_sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Packet controller on the read side of the UART receive FIFO, in the sclk domain.
- Pops bytes from the RX FIFO and groups them into packets of a programmed size.
- Presents bytes downstream on a valid/ready stream with a last marker.
- Enforces an inter-byte idle timeout and collects sticky error status (parity, FIFO overflow, timeout) for the host.

Parameters:
TIMEOUT_W, 16, width of the inter-byte idle timeout counter and of timeout_r

Ports:
sclk  in  1  system clock; all logic on rising edge
rstn  in  1  reset, synchronous, active-low
enable_i  in  1  controller enable; deassertion aborts any packet in progress
data_size_r  in  16  bytes per packet; 0 is treated as 1
timeout_r  in  TIMEOUT_W  max idle sclk cycles between bytes inside a packet; 0 disables the timeout
fifo_empty_i  in  1  RX FIFO empty
fifo_rd_o  out  1  RX FIFO read strobe; data valid the following cycle
fifo_data_i  in  8  RX FIFO read data
parity_err_i  in  1  parity error indication from the receiver (level or pulse)
fifo_full_err_i  in  1  write-while-full pulse from the receiver
pkt_data_o  out  8  downstream byte
pkt_valid_o  out  1  downstream valid
pkt_ready_i  in  1  downstream ready
pkt_last_o  out  1  high with pkt_valid_o on the final byte of a packet
pkt_done_o  out  1  one-cycle pulse after the final byte is accepted
timeout_o  out  1  one-cycle pulse when a packet is aborted by timeout
err_status_o  out  3  sticky {timeout, overflow, parity}
err_clr_i  in  1  clears err_status_o
irq_o  out  1  OR of err_status_o bits, plus pkt_done_o
byte_cnt_o  out  16  bytes accepted in the current packet

Behaviour:
Reset and outputs:
- rstn low at a clock edge: state=IDLE; all outputs 0; byte_cnt=0; timeout counter=0; size_q=1.

States:
- IDLE: no packet open. If enable_i && !fifo_empty_i: latch size_q = (data_size_r==0 ? 1 : data_size_r), go to RD.
- GAP: packet open, waiting for the next byte.
  - Timeout counter increments every cycle.
  - If !fifo_empty_i: clear counter, go to RD.
  - Else if timeout_r!=0 && counter==timeout_r-1: pulse timeout_o, set sticky bit[2], clear byte_cnt, go to IDLE.
  - A non-empty FIFO in the expiry cycle wins: go to RD, no timeout.
- RD: fifo_rd_o=1 for exactly this cycle; go to LAT.
- LAT: register fifo_data_i into pkt_data_o; pkt_last_o = (byte_cnt+1==size_q); go to OUT.
- OUT: pkt_valid_o=1; pkt_data_o and pkt_last_o held stable until handshake.
  - On pkt_valid_o && pkt_ready_i: byte_cnt+1.
  - If this was the last byte: go to DONE. Else: go to GAP with counter cleared.
- DONE: pkt_done_o=1 for one cycle; byte_cnt cleared; go to IDLE.

Rules:
- Throughput: max one byte per 4 cycles (RD, LAT, OUT, GAP/DONE); downstream back-pressure stalls in OUT indefinitely, with no timeout counting in OUT.
- data_size_r changes take effect only at the next packet start (size_q).
- enable_i low in any state: next state IDLE, pkt_valid_o dropped, byte_cnt cleared, no pkt_done_o/timeout_o. A byte already popped in RD/LAT is discarded. fifo_rd_o never asserts while enable_i is low.
- Sticky errors:
  - parity_err_i high sets bit[0]; fifo_full_err_i high sets bit[1].
  - err_clr_i clears all bits; a set in the same cycle as err_clr_i wins.
  - Errors never abort a packet.
- byte_cnt width is 16 bits; size_q ≤ 65535, so no wrap within a packet.
- fifo_rd_o is decoded only from the registered state and is never asserted while fifo_empty_i was high in the deciding cycle.

Test Plan:
- size=3, timeout_r=0, three bytes 0x11,0x22,0x33 in FIFO, ready=1 -> three fifo_rd_o pulses; bytes out in order; pkt_last_o only with 0x33; one pkt_done_o; byte_cnt_o returns to 0.
- size=2, one byte 0x5A, timeout_r=10 -> 0x5A delivered; after 10 GAP cycles, timeout_o pulse; err_status_o=3'b100; next byte starts a new packet with byte_cnt=0.
- size=1, pkt_ready_i low for 20 cycles -> pkt_valid_o and pkt_data_o held stable; no extra fifo_rd_o; no timeout.
- enable_i dropped in LAT of byte 2 of 4 -> IDLE next cycle, no pkt_done_o, byte_cnt_o=0; re-enable starts a fresh packet.
- parity_err_i pulse coincident with err_clr_i -> bit[0] remains 1; err_clr_i alone next cycle -> 3'b000 and irq_o=0.
- data_size_r=0 -> each byte delivered with pkt_last_o=1, followed by pkt_done_o.
